// File: rtl/clint_timer.sv
// CLINT-style machine timer block: one shared 64-bit mtime with prescaler and
// count enable, per-hart mtimecmp comparators with registered timer interrupts,
// and per-hart software interrupt bits. Word-addressed peripheral bus slave.
module clint_timer #(
    parameter int          NHART    = 2,
    parameter int          PRESCALE = 1,
    parameter logic [63:0] CMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [15:0]      addr,
    input  logic [2:0]       we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [NHART-1:0] int_timer,
    output logic [NHART-1:0] int_soft
);

    // Word addresses (byte address >> 2)
    localparam logic [13:0] CMP_BASE_W = 14'h1000;
    localparam logic [13:0] CTRL_W     = 14'h2FFC;
    localparam logic [13:0] MTIME_L_W  = 14'h2FFE;
    localparam logic [13:0] MTIME_H_W  = 14'h2FFF;
    localparam logic [15:0] PS_LAST    = 16'(PRESCALE - 1);

    logic [13:0]      waddr;
    logic             unused_addr_lsb;
    logic             wr_en;
    logic [NHART-1:0] msip_wr;
    logic [NHART-1:0] cmp_lo_wr;
    logic [NHART-1:0] cmp_hi_wr;

    logic [NHART-1:0] msip;
    logic [63:0]      mtimecmp [NHART];
    logic [63:0]      mtime;
    logic [15:0]      ps_count;
    logic             en;
    logic             tick;

    assign waddr           = addr[15:2];
    assign unused_addr_lsb = ^addr[1:0];
    // Only full-word stores are accepted; sub-word sizes are dropped entirely.
    assign wr_en           = sel && we[2] && (we[1:0] == 2'b10);
    assign tick            = en && (ps_count == PS_LAST);
    assign int_soft        = msip;

    // Per-hart write decode for msip and both mtimecmp halves
    always_comb begin
        msip_wr   = '0;
        cmp_lo_wr = '0;
        cmp_hi_wr = '0;
        for (int h = 0; h < NHART; h++) begin
            msip_wr[h]   = wr_en && (waddr == 14'(h));
            cmp_lo_wr[h] = wr_en && (waddr == CMP_BASE_W + 14'(2 * h));
            cmp_hi_wr[h] = wr_en && (waddr == CMP_BASE_W + 14'(2 * h + 1));
        end
    end

    // Software interrupt bits; only bit 0 of the write data is kept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msip <= '0;
        end else begin
            for (int h = 0; h < NHART; h++) begin
                if (msip_wr[h]) msip[h] <= wdata[0];
            end
        end
    end

    // Compare registers, written one 32-bit half at a time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int h = 0; h < NHART; h++) mtimecmp[h] <= CMP_RST;
        end else begin
            for (int h = 0; h < NHART; h++) begin
                if (cmp_lo_wr[h]) mtimecmp[h][31:0]  <= wdata;
                if (cmp_hi_wr[h]) mtimecmp[h][63:32] <= wdata;
            end
        end
    end

    // Count enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en <= 1'b1;
        end else if (wr_en && (waddr == CTRL_W)) begin
            en <= wdata[0];
        end
    end

    // Prescaler: holds its phase while disabled so re-enabling resumes mid-period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_count <= '0;
        end else if (en) begin
            ps_count <= tick ? '0 : ps_count + 16'd1;
        end
    end

    // mtime: a bus write to either half wins over the tick that cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime <= '0;
        end else if (wr_en && (waddr == MTIME_L_W)) begin
            mtime[31:0] <= wdata;
        end else if (wr_en && (waddr == MTIME_H_W)) begin
            mtime[63:32] <= wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // Registered level-sensitive timer interrupts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_timer <= '0;
        end else begin
            for (int h = 0; h < NHART; h++) int_timer[h] <= (mtime >= mtimecmp[h]);
        end
    end

    // Combinational read mux; unmapped words read zero
    always_comb begin
        rdata = '0;
        if (sel) begin
            for (int h = 0; h < NHART; h++) begin
                if (waddr == 14'(h))                     rdata = {31'b0, msip[h]};
                if (waddr == CMP_BASE_W + 14'(2 * h))     rdata = mtimecmp[h][31:0];
                if (waddr == CMP_BASE_W + 14'(2 * h + 1)) rdata = mtimecmp[h][63:32];
            end
            if (waddr == CTRL_W)    rdata = {31'b0, en};
            if (waddr == MTIME_L_W) rdata = mtime[31:0];
            if (waddr == MTIME_H_W) rdata = mtime[63:32];
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer (NHART = 2, PRESCALE = 4).
module tb_clint_timer;

    localparam logic [15:0] MSIP0   = 16'h0000;
    localparam logic [15:0] MSIP1   = 16'h0004;
    localparam logic [15:0] MSIP2   = 16'h0008;
    localparam logic [15:0] CMP0_L  = 16'h4000;
    localparam logic [15:0] CMP0_H  = 16'h4004;
    localparam logic [15:0] CMP2_L  = 16'h4010;
    localparam logic [15:0] CTRL    = 16'hBFF0;
    localparam logic [15:0] MTIME_L = 16'hBFF8;
    localparam logic [15:0] MTIME_H = 16'hBFFC;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        sel   = 1'b0;
    logic [15:0] addr  = '0;
    logic [2:0]  we    = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [1:0]  int_timer;
    logic [1:0]  int_soft;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    clint_timer #(.NHART(2), .PRESCALE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .addr      (addr),
        .we        (we),
        .wdata     (wdata),
        .rdata     (rdata),
        .int_timer (int_timer),
        .int_soft  (int_soft)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        sel  = 1'b1;
        addr = a;
        we   = 3'b000;
        #1;
        d    = rdata;
        sel  = 1'b0;
    endtask

    task automatic wrw(input logic [15:0] a, input logic [31:0] d, input logic [2:0] w);
        @(negedge clk);
        sel   = 1'b1;
        addr  = a;
        we    = w;
        wdata = d;
        @(negedge clk);
        sel   = 1'b0;
        we    = 3'b000;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        wrw(a, d, 3'b110);
    endtask

    // Sample mtime_l every negedge until it leaves base (at most 8 cycles)
    task automatic wait_tick(input logic [31:0] base, output logic seen, output logic [31:0] d);
        seen = 1'b0;
        d    = base;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd(MTIME_L, d);
            if (d != base) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        seen;
        logic        prev_ge;
        logic        rose;

        // Reset state, read while reset is held
        #12;
        rd(MSIP0, d);   check("rst_msip0", d, 32'h0);
        rd(CMP0_L, d);  check("rst_cmp0_l", d, 32'hFFFF_FFFF);
        rd(CMP0_H, d);  check("rst_cmp0_h", d, 32'hFFFF_FFFF);
        rd(CTRL, d);    check("rst_ctrl", d, 32'h1);
        rd(MTIME_L, d); check("rst_mtime_l", d, 32'h0);
        addr = CTRL; sel = 1'b0; #1;
        check("sel0_rdata", rdata, 32'h0);
        check("rst_int_timer", int_timer, 2'b00);
        check("rst_int_soft", int_soft, 2'b00);

        // Prescale 4: 40 clocks after release gives mtime = 10
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        rd(MTIME_L, d); check("ps_mtime_40clk", d, 32'd10);

        // Freeze: count held at 2 when en drops
        wr(CTRL, 32'h0);
        rd(MTIME_L, d); check("freeze_mtime_a", d, 32'd10);
        repeat (20) @(negedge clk);
        rd(MTIME_L, d); check("freeze_mtime_b", d, 32'd10);
        rd(CTRL, d);    check("freeze_ctrl", d, 32'h0);

        // Resume from held count: tick on the second clock after re-enable
        wr(CTRL, 32'h1);
        rd(MTIME_L, d); check("resume_mtime_0", d, 32'd10);
        @(negedge clk);
        rd(MTIME_L, d); check("resume_mtime_1", d, 32'd10);
        @(negedge clk);
        rd(MTIME_L, d); check("resume_mtime_2", d, 32'd11);

        // Software interrupts
        wr(MSIP1, 32'hFFFF_FFFF);
        rd(MSIP1, d);   check("msip1_read", d, 32'h1);
        rd(MSIP0, d);   check("msip0_read", d, 32'h0);
        check("int_soft_set", int_soft, 2'b10);
        wr(MSIP1, 32'h0);
        check("int_soft_clr", int_soft, 2'b00);
        wrw(MSIP1, 32'h1, 3'b100);
        check("int_soft_subword", int_soft, 2'b00);
        rd(MSIP1, d);   check("msip1_subword", d, 32'h0);
        wr(MSIP2, 32'h1);
        rd(MSIP2, d);   check("msip2_unmapped", d, 32'h0);
        check("int_soft_unmapped", int_soft, 2'b00);
        wr(CMP2_L, 32'h1234);
        rd(CMP2_L, d);  check("cmp2_unmapped", d, 32'h0);

        // Carry from low into high word
        wr(CTRL, 32'h0);
        wr(MTIME_H, 32'h0);
        wr(MTIME_L, 32'hFFFF_FFFF);
        rd(MTIME_L, d); check("carry_pre_l", d, 32'hFFFF_FFFF);
        rd(MTIME_H, d); check("carry_pre_h", d, 32'h0);
        wr(CTRL, 32'h1);
        wait_tick(32'hFFFF_FFFF, seen, d);
        check("carry_tick_seen", seen, 1'b1);
        check("carry_l", d, 32'h0);
        rd(MTIME_H, d); check("carry_h", d, 32'h1);
        wr(CTRL, 32'h0);

        // Full 64-bit wrap
        wr(MTIME_L, 32'hFFFF_FFFF);
        wr(MTIME_H, 32'hFFFF_FFFF);
        rd(MTIME_H, d); check("wrap_pre_h", d, 32'hFFFF_FFFF);
        wr(CTRL, 32'h1);
        wait_tick(32'hFFFF_FFFF, seen, d);
        check("wrap_tick_seen", seen, 1'b1);
        check("wrap_l", d, 32'h0);
        rd(MTIME_H, d); check("wrap_h", d, 32'h0);
        wr(CTRL, 32'h0);

        // Timer interrupt: mtimecmp[0] = 20, mtime from 0
        wr(MTIME_L, 32'h0);
        wr(MTIME_H, 32'h0);
        wr(CMP0_H, 32'h0);
        wr(CMP0_L, 32'd20);
        @(negedge clk);
        check("irq_before", int_timer, 2'b00);
        wr(CTRL, 32'h1);
        prev_ge = 1'b0;
        rose    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("irq0_track", int_timer[0], prev_ge);
            check("irq1_quiet", int_timer[1], 1'b0);
            if (int_timer[0]) rose = 1'b1;
            rd(MTIME_L, d);
            prev_ge = (d >= 32'd20);
        end
        check("irq0_rose", rose, 1'b1);
        wr(CMP0_L, 32'd1000);
        check("irq0_hold_1clk", int_timer[0], 1'b1);
        @(negedge clk);
        check("irq0_fall_2clk", int_timer[0], 1'b0);

        // Write to mtime_l colliding with a tick
        rd(MTIME_L, d);
        wait_tick(d, seen, d);
        check("coll_sync_seen", seen, 1'b1);
        repeat (2) @(negedge clk);
        wr(MTIME_L, 32'd5);
        rd(MTIME_L, d); check("coll_write_wins", d, 32'd5);
        rd(MTIME_H, d); check("coll_h_holds", d, 32'h0);
        repeat (3) @(negedge clk);
        rd(MTIME_L, d); check("coll_no_early_tick", d, 32'd5);
        @(negedge clk);
        rd(MTIME_L, d); check("coll_next_tick", d, 32'd6);

        // Asynchronous reset mid-count
        wr(MSIP0, 32'h1);
        wr(CMP0_L, 32'h0);
        @(negedge clk);
        check("pre_rst_int_timer", int_timer, 2'b01);
        check("pre_rst_int_soft", int_soft, 2'b01);
        #1 rst = 1'b1;
        #1;
        check("arst_int_timer", int_timer, 2'b00);
        check("arst_int_soft", int_soft, 2'b00);
        rd(MTIME_L, d); check("arst_mtime_l", d, 32'h0);
        rd(CMP0_L, d);  check("arst_cmp0_l", d, 32'hFFFF_FFFF);
        rd(MSIP0, d);   check("arst_msip0", d, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Parametrised successor to the single-hart machine timer.
- Provides a RISC-V CLINT-style block: NHART software-interrupt bits, NHART 64-bit mtimecmp comparators, and one shared 64-bit mtime counter.
- Adds a prescaler, a count-enable control, a writable mtime, and registered per-hart interrupt outputs.
- Sits on the peripheral bus (sel/addr/we/wdata/rdata) beside the other memory-mapped peripherals.

Parameters:
- NHART, 2, number of harts (1..8); sets msip/mtimecmp/interrupt vector count.
- PRESCALE, 1, clk cycles per mtime increment (1..65535); 1 means increment every clock.
- CMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of every mtimecmp, so no timer interrupt fires out of reset.

Ports:
- clk  in  1  global clock.
- rst  in  1  asynchronous, active-high reset.
- sel  in  1  block select.
- addr  in  16  byte address within block.
- we  in  3  we[2] = write strobe; we[1:0] = size (2'b10 = word).
- wdata  in  32  write data.
- rdata  out  32  read data, combinational.
- int_timer  out  NHART  per-hart machine timer interrupt, registered.
- int_soft  out  NHART  per-hart machine software interrupt (msip bit 0).

Behaviour:
- Clock and reset:
  - Reset is asynchronous and active-high. All state is clocked on posedge clk.
  - Reset values: msip = 0; mtimecmp[h] = CMP_RST; mtime = 0; prescaler count = 0; ctrl.en = 1; int_timer = 0; int_soft = 0.
  - rdata is 0 whenever sel = 0.
- Address map (word-aligned; addr[1:0] ignored):
  - 0x0000 + 4*h: msip[h]. Only bit 0 is stored; reads return {31'b0, msip[h]}.
  - 0x4000 + 8*h: mtimecmp[h][31:0].
  - 0x4004 + 8*h: mtimecmp[h][63:32].
  - 0xBFF0: ctrl. Bit 0 is en; other bits read 0.
  - 0xBFF8: mtime[31:0].
  - 0xBFFC: mtime[63:32].
  - Unmapped addresses, including hart indices >= NHART, read 0 and ignore writes.
- Writes:
  - A write happens on the posedge where sel = 1, we[2] = 1 and we[1:0] = 2'b10.
  - Any other we[1:0] with we[2] = 1 is ignored; no partial-word updates.
  - Read-after-write data is visible on the next cycle.
- Prescaler:
  - When en = 1, the count increments each clk.
  - When count == PRESCALE-1, count returns to 0 and a one-cycle tick is asserted.
  - When en = 0, count holds and no tick is produced.
  - PRESCALE = 1 gives a tick every cycle while en = 1.
  - Writing ctrl.en = 0 to 1 resumes from the held count; the count is not cleared.
- mtime:
  - On tick, mtime is incremented as a full 64-bit value, with carry from the low word into the high word.
  - 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
  - A bus write to either mtime half in the same cycle as a tick takes priority: the written half takes wdata, the other half holds, and the increment for that tick is lost.
  - The prescaler count is unaffected by mtime writes.
- int_timer:
  - int_timer[h] <= (mtime >= mtimecmp[h]), unsigned 64-bit compare, registered.
  - It asserts one clk after the condition becomes true, using the post-update register values.
  - It stays asserted while the condition holds and is level-sensitive (no clear-on-read).
  - Writing mtimecmp[h] above mtime deasserts int_timer[h] on the second clk after the write (register update, then compare register).
  - A 32-bit half-write can create a transient compare. Software writes the high word to all-ones first; the hardware does not guard against this.
- int_soft: int_soft[h] = msip[h] register output, asserted one cycle after the write.
- rdata:
  - For mtime, rdata reflects the current register, so the low and high reads are not atomic.
  - No read side effects anywhere.

Test Plan:
- Reset, then sel = 1, read 0x0000, 0x4000, 0x4004, 0xBFF0, 0xBFF8 -> 0, FFFFFFFF, FFFFFFFF, 1, 0. Read with sel = 0 -> 0. int_timer = 0.
- Write 0xFFFFFFFF to 0x0004 (hart 1), then read -> 0x00000001 and int_soft = 2'b10. Write 0 -> int_soft = 0. Write with we = 3'b1_00 -> no change.
- PRESCALE = 4, en = 1: after 40 clk from reset, mtime = 10. Write ctrl = 0, wait 20 clk -> mtime unchanged. Write ctrl = 1 -> counting resumes.
- Force-free carry check: write mtime_h = 0, mtime_l = FFFFFFFF, then after one tick read mtime_h = 1 and mtime_l = 0. Write both halves to FFFFFFFF -> after one tick mtime = 0.
- Interrupt check: write mtimecmp[0] = {0, 20} with mtime = 0 and PRESCALE = 1 -> int_timer[0] rises one clk after mtime reaches 20, and int_timer[1] stays 0. Write mtimecmp[0]_l = 1000 -> int_timer[0] falls 2 clk later.
- Collision check: write mtime_l = 5 in the same cycle as a tick -> read 5 (not 6). Reset asserted mid-count -> all state returns to reset values immediately, asynchronously.
